branch_hazard_ctrl: RTL
=======================

Name: branch_hazard_ctrl

Overview:
ID-stage branch control that sits directly upstream of the branch forwarding unit and consumes its branchFWDA/branchFWDB selects.
- Detects data hazards that prevent resolving a beq/bne in ID and stalls IF/ID for the required cycles.
- Once operands are available, picks them via the forwarding selects, compares them, and drives pcSrc and the IF/ID flush.
- Also covers the ordinary load-use stall.

Parameters:
DATA_W, 32, operand width
REG_W, 5, register index width
CNT_W, 16, stats counter width (used only with the optional feature)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
IFID_branch  in  1  instruction in ID is beq
IFID_bne  in  1  instruction in ID is bne (with IFID_branch=0)
IFID_rs  in  REG_W  ID source register A
IFID_rt  in  REG_W  ID source register B
IDEX_rd  in  REG_W  destination register in EX
IDEX_regWrite  in  1  EX instruction writes a register
IDEX_memRead  in  1  EX instruction is a load
EXMEM_rd  in  REG_W  destination register in MEM
EXMEM_memRead  in  1  MEM instruction is a load
branchFWDA  in  2  operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback data
branchFWDB  in  2  operand B select, same encoding
rfA  in  DATA_W  regfile read A
rfB  in  DATA_W  regfile read B
exmemALU  in  DATA_W  EX/MEM ALU result
memwbData  in  DATA_W  MEM/WB writeback data
PC_write  out  1  PC update enable
IFID_write  out  1  IF/ID update enable
IDEX_bubble  out  1  insert a NOP into ID/EX
IFID_flush  out  1  squash the fetched instruction
pcSrc  out  1  select the branch target
stalling  out  1  FSM is not in RUN

Behaviour:
- States: RUN, HOLD. A REG_W-agnostic 2-bit counter cnt holds the remaining stall cycles.
- Reset (Reset=0, async): state=RUN, cnt=0. Every output is 0 except PC_write=1 and IFID_write=1.
- Hazard match is match(x) = (x!=0) && (x==IFID_rs || x==IFID_rt). Register 0 never creates a hazard.
- In RUN, the required stall count need is evaluated combinationally, first match wins:
  1. Branch and IDEX_memRead and match(IDEX_rd): need=2.
  2. Branch and IDEX_regWrite and match(IDEX_rd): need=1.
  3. Branch and EXMEM_memRead and match(EXMEM_rd): need=1.
  4. Non-branch and IDEX_memRead and match(IDEX_rd): need=1 (load-use).
  5. Otherwise need=0.
- need>0 in RUN: in the same cycle PC_write=0, IFID_write=0, IDEX_bubble=1, pcSrc=0.
  - If need=1, the next state is RUN with cnt=0, and the condition is re-evaluated on the next cycle.
  - If need=2, the next state is HOLD with cnt=1.
- HOLD: PC_write=0, IFID_write=0, IDEX_bubble=1, pcSrc=0, stalling=1.
  - cnt decrements each cycle.
  - At cnt=0 the next state is RUN and conditions are re-evaluated there; hazards are not re-checked while in HOLD.
- need=0 in RUN with a branch:
  - opA = mux(branchFWDA), opB = mux(branchFWDB). Select code 11 behaves as 00.
  - taken = beq ? (opA==opB) : (opA!=opB).
  - When taken: pcSrc=1 and IFID_flush=1 in the same cycle, for one cycle only. PC and IF/ID stay enabled.
- Non-branch with no hazard: pass-through (PC_write=1, IFID_write=1, all else 0).
- IFID_branch and IFID_bne both 1 is illegal; it is treated as beq.
- Reset asserted mid-HOLD aborts the stall immediately. No pcSrc is produced for the aborted branch.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds output ports stallCycles and takenCount, each CNT_W bits.
  - stallCycles increments on every cycle with IDEX_bubble=1.
  - takenCount increments on every cycle with pcSrc=1.
  - Both counters saturate at all-ones and clear on Reset.
- Undefined: no ports and no registers are added; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - forwarding select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - state constants ST_RUN, ST_HOLD;
  - the REG_W and DATA_W defaults.
- One sub-module, branch_compare: two 3:1 operand muxes plus the eq/ne compare; output taken.

Test Plan:
- beq with IFID_rs=1, IFID_rt=2, IDEX_memRead=1, IDEX_regWrite=1, IDEX_rd=1 -> IDEX_bubble=1 for exactly 2 cycles, stalling=1 in the second cycle, then RUN.
- beq, IDEX_regWrite=1, IDEX_rd=2 (ALU op) -> 1 stall cycle. Next cycle: branchFWDA=00, branchFWDB=01, rfA=7, exmemALU=7 -> pcSrc=1, IFID_flush=1 for one cycle.
- bne, no hazard, FWDA=10, FWDB=00, memwbData=5, rfB=5 -> pcSrc=0, IFID_flush=0, PC_write=1.
- Load-use: non-branch instruction, IFID_rt=3, IDEX_memRead=1, IDEX_rd=3 -> one bubble. With IDEX_rd=0 instead -> no bubble.
- Reset pulled low during HOLD (cnt=1) -> outputs return to reset values immediately and state=RUN. After release the same hazard re-stalls.
- With BRANCH_STATS_EN defined: 3 stall cycles and 2 taken branches -> stallCycles=3, takenCount=2. Preload near saturation and keep incrementing -> counter holds at all-ones.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared constants and types for the ID-stage branch control:
//                forwarding select codes, FSM state encoding and width defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_DATA_W_DEFAULT = 32;
    localparam int c_REG_W_DEFAULT  = 5;

    // Operand select codes driven by the branch forwarding unit; 2'b11 is
    // treated the same as FWD_RF.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/branch_compare.sv
`default_nettype none
// ============================================================================
//  Module      : branch_compare
//  Description : Selects the two branch operands from the regfile or the
//                forwarding paths and evaluates the beq / bne condition.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_compare
    import mips_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic [1:0]        i_fwdA,
    input  logic [1:0]        i_fwdB,
    input  logic              i_isBeq,
    input  logic [DATA_W-1:0] i_rfA,
    input  logic [DATA_W-1:0] i_rfB,
    input  logic [DATA_W-1:0] i_exmemAlu,
    input  logic [DATA_W-1:0] i_memwbData,
    output logic              o_taken
);

    logic [DATA_W-1:0] w_opA;
    logic [DATA_W-1:0] w_opB;

    // Operand A mux; unused code 2'b11 falls back to the regfile value.
    always_comb begin
        w_opA = i_rfA;
        case (i_fwdA)
            FWD_EXMEM: w_opA = i_exmemAlu;
            FWD_MEMWB: w_opA = i_memwbData;
            default:   w_opA = i_rfA;
        endcase
    end

    // Operand B mux; same encoding as operand A.
    always_comb begin
        w_opB = i_rfB;
        case (i_fwdB)
            FWD_EXMEM: w_opB = i_exmemAlu;
            FWD_MEMWB: w_opB = i_memwbData;
            default:   w_opB = i_rfB;
        endcase
    end

    assign o_taken = i_isBeq ? (w_opA == w_opB) : (w_opA != w_opB);

endmodule : branch_compare
`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_hazard_ctrl
//  Description : ID-stage branch resolution control. Stalls IF/ID while a
//                beq/bne operand is still in flight (or on a load-use hazard),
//                then compares the forwarded operands and drives pcSrc plus the
//                IF/ID flush.
//                Optional build macro BRANCH_STATS_EN adds saturating
//                stallCycles / takenCount statistics outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int REG_W  = c_REG_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IFID_branch,
    input  logic              IFID_bne,
    input  logic [REG_W-1:0]  IFID_rs,
    input  logic [REG_W-1:0]  IFID_rt,
    input  logic [REG_W-1:0]  IDEX_rd,
    input  logic              IDEX_regWrite,
    input  logic              IDEX_memRead,
    input  logic [REG_W-1:0]  EXMEM_rd,
    input  logic              EXMEM_memRead,
    input  logic [1:0]        branchFWDA,
    input  logic [1:0]        branchFWDB,
    input  logic [DATA_W-1:0] rfA,
    input  logic [DATA_W-1:0] rfB,
    input  logic [DATA_W-1:0] exmemALU,
    input  logic [DATA_W-1:0] memwbData,
    output logic              PC_write,
    output logic              IFID_write,
    output logic              IDEX_bubble,
    output logic              IFID_flush,
    output logic              pcSrc,
    output logic              stalling
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  stallCycles,
    output logic [CNT_W-1:0]  takenCount
`endif
);

    state_t     r_state;
    state_t     w_stateNext;
    logic [1:0] r_cnt;
    logic [1:0] w_cntNext;

    logic       w_isBranch;
    logic       w_isBeq;
    logic       w_matchEx;
    logic       w_matchMem;
    logic       w_taken;
    logic [1:0] w_need;

    // A set IFID_branch wins over IFID_bne, so the illegal both-set case is a beq.
    assign w_isBranch = IFID_branch | IFID_bne;
    assign w_isBeq    = IFID_branch;

    // Register 0 is hard-wired, so it can never be the source of a hazard.
    assign w_matchEx  = (IDEX_rd != '0)  && ((IDEX_rd == IFID_rs)  || (IDEX_rd == IFID_rt));
    assign w_matchMem = (EXMEM_rd != '0) && ((EXMEM_rd == IFID_rs) || (EXMEM_rd == IFID_rt));

    branch_compare #(
        .DATA_W (DATA_W)
    ) u_compare (
        .i_fwdA      (branchFWDA),
        .i_fwdB      (branchFWDB),
        .i_isBeq     (w_isBeq),
        .i_rfA       (rfA),
        .i_rfB       (rfB),
        .i_exmemAlu  (exmemALU),
        .i_memwbData (memwbData),
        .o_taken     (w_taken)
    );

    // Stall cycles needed before the ID instruction can proceed; first match wins.
    always_comb begin
        w_need = 2'd0;
        if (w_isBranch && IDEX_memRead && w_matchEx) begin
            w_need = 2'd2;
        end else if (w_isBranch && IDEX_regWrite && w_matchEx) begin
            w_need = 2'd1;
        end else if (w_isBranch && EXMEM_memRead && w_matchMem) begin
            w_need = 2'd1;
        end else if (!w_isBranch && IDEX_memRead && w_matchEx) begin
            w_need = 2'd1;
        end
    end

    // State and remaining-stall counter; reset aborts any stall in progress.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state and output decode; outputs are forced to idle while in reset.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        pcSrc       = 1'b0;
        stalling    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_need != 2'd0) begin
                    PC_write    = 1'b0;
                    IFID_write  = 1'b0;
                    IDEX_bubble = 1'b1;
                    if (w_need == 2'd2) begin
                        w_stateNext = ST_HOLD;
                        w_cntNext   = 2'd1;
                    end else begin
                        w_stateNext = ST_RUN;
                        w_cntNext   = 2'd0;
                    end
                end else if (w_isBranch && w_taken) begin
                    pcSrc      = 1'b1;
                    IFID_flush = 1'b1;
                end
            end
            ST_HOLD: begin
                PC_write    = 1'b0;
                IFID_write  = 1'b0;
                IDEX_bubble = 1'b1;
                stalling    = 1'b1;
                // Hazards are not re-checked here; leave once the count runs out.
                if (r_cnt <= 2'd1) begin
                    w_stateNext = ST_RUN;
                    w_cntNext   = 2'd0;
                end else begin
                    w_cntNext   = r_cnt - 2'd1;
                end
            end
            default: begin
                w_stateNext = ST_RUN;
                w_cntNext   = 2'd0;
            end
        endcase

        if (!Reset) begin
            PC_write    = 1'b1;
            IFID_write  = 1'b1;
            IDEX_bubble = 1'b0;
            IFID_flush  = 1'b0;
            pcSrc       = 1'b0;
            stalling    = 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_takenCount;

    // Saturating event counters for bubbles inserted and branches taken.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_stallCycles <= '0;
            r_takenCount  <= '0;
        end else begin
            if (IDEX_bubble && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + 1'b1;
            end
            if (pcSrc && (r_takenCount != '1)) begin
                r_takenCount <= r_takenCount + 1'b1;
            end
        end
    end

    assign stallCycles = r_stallCycles;
    assign takenCount  = r_takenCount;
`else
    // Keeps the statistics width parameter referenced when the counters are absent.
    logic w_unusedCntW;
    assign w_unusedCntW = |CNT_W;
`endif

endmodule : branch_hazard_ctrl
`default_nettype wire
